pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/barrel_pkg.sv | 20 ++
 rtl/shift_stage.sv | 79 +++++++
 rtl/pipelined_barrel_shifter.sv | 63 ++++++
 tb/tb_pipelined_barrel_shifter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared encodings for the pipelined barrel shifter: shift modes and direction values.
// Rotate support is selected at build time by the BARREL_ROTATE_EN macro (see shift_stage).
package barrel_pkg;

   typedef enum logic [1:0] {
      MODE_LOG = 2'b00,
      MODE_ARI = 2'b01,
      MODE_ROT = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   // Only right shifts in arithmetic mode replicate the sign; left arithmetic is logical.
   function automatic logic isSignFill(input logic [1:0] mode, input logic dir);
      return (mode == MODE_ARI) && (dir == DIR_RIGHT);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: conditional shift by 2^STAGE plus its register.
// Rotate paths exist only when BARREL_ROTATE_EN is defined; otherwise mode 10 shifts logically.
module shift_stage
   import barrel_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int STAGE = 0,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic [SHW-1:0]   i_shamt,
   input  logic             i_dir,
   input  logic [1:0]       i_mode,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [SHW-1:0]   o_shamt,
   output logic             o_dir,
   output logic [1:0]       o_mode
);

   localparam int AMT = 1 << STAGE;

   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_stageOut;

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SHW-1:0]   r_shamt;
   logic             r_dir;
   logic [1:0]       r_mode;

   // The data MSB still holds the original sign after any earlier arithmetic stage.
   always_comb begin
      w_shifted = i_data >> AMT;
      if (i_dir == DIR_LEFT) begin
         w_shifted = i_data << AMT;
      end else if (isSignFill(i_mode, i_dir)) begin
         w_shifted = {{AMT{i_data[WIDTH-1]}}, i_data[WIDTH-1:AMT]};
      end
`ifdef BARREL_ROTATE_EN
      if (i_mode == MODE_ROT) begin
         if (i_dir == DIR_LEFT) begin
            w_shifted = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
         end else begin
            w_shifted = {i_data[AMT-1:0], i_data[WIDTH-1:AMT]};
         end
      end
`endif
   end

   assign w_stageOut = i_shamt[STAGE] ? w_shifted : i_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shamt <= '0;
         r_dir   <= 1'b0;
         r_mode  <= 2'b00;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_data  <= w_stageOut;
         r_shamt <= i_shamt;
         r_dir   <= i_dir;
         r_mode  <= i_mode;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_shamt = r_shamt;
   assign o_dir   = r_dir;
   assign o_mode  = r_mode;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW registered shift_stage instances with a global stall.
// Define BARREL_ROTATE_EN to build rotate support for mode 10.
module pipelined_barrel_shifter
   import barrel_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic             in_dir,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             w_advance;
   logic             w_valid [SHW+1];
   logic [WIDTH-1:0] w_data  [SHW+1];
   logic [SHW-1:0]   w_shamt [SHW+1];
   logic             w_dir   [SHW+1];
   logic [1:0]       w_mode  [SHW+1];

   // Whole pipeline moves together; it only stalls when a finished result is not taken.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   assign w_valid[0] = in_valid;
   assign w_data[0]  = in_data;
   assign w_shamt[0] = in_shamt;
   assign w_dir[0]   = in_dir;
   assign w_mode[0]  = in_mode;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .STAGE (k)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_advance),
         .i_valid (w_valid[k]),
         .i_data  (w_data[k]),
         .i_shamt (w_shamt[k]),
         .i_dir   (w_dir[k]),
         .i_mode  (w_mode[k]),
         .o_valid (w_valid[k+1]),
         .o_data  (w_data[k+1]),
         .o_shamt (w_shamt[k+1]),
         .o_dir   (w_dir[k+1]),
         .o_mode  (w_mode[k+1])
      );
   end

   assign out_valid = w_valid[SHW];
   assign out_data  = w_data[SHW];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): directed cases, backpressure,
// mid-stream reset and a randomized run against a queue-based reference model.
module tb_pipelined_barrel_shifter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_shamt;
   logic       in_dir;
   logic [1:0] in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   int checkCount = 0;
   int failCount  = 0;
   int acceptCount;
   int consumeCount;
   logic [7:0] expQ [$];

   pipelined_barrel_shifter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_dir    (in_dir),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // Reference: shift amount applied in one step with integer arithmetic.
   function automatic logic [7:0] refModel(input logic [7:0] d, input logic [2:0] s,
                                           input logic dir, input logic [1:0] m);
      int unsigned x  = d;
      int unsigned sh = s;
      int unsigned r;
      logic rot = (m == 2'b10);
`ifndef BARREL_ROTATE_EN
      rot = 1'b0;
`endif
      if (rot && dir)        r = (x << sh) | (x >> (8 - sh));
      else if (rot)          r = (x >> sh) | (x << (8 - sh));
      else if (dir)          r = x << sh;
      else if (m == 2'b01 && d[7]) r = (x | 32'hFFFF_FF00) >> sh;
      else                   r = x >> sh;
      return r[7:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One cycle: drive at negedge, then check outputs and update the scoreboard before the next edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] s,
                                input logic dir, input logic [1:0] m, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_shamt  = s;
      in_dir    = dir;
      in_mode   = m;
      out_ready = ordy;
      #1;
      if (out_valid) begin
         if (expQ.size() == 0) checkOutput("spurious_valid", {31'd0, out_valid}, 32'd0);
         else                  checkOutput("out_data", {24'd0, out_data}, {24'd0, expQ[0]});
         if (out_ready) begin
            if (expQ.size() > 0) void'(expQ.pop_front());
            consumeCount++;
         end
      end
      if (in_valid && in_ready) begin
         expQ.push_back(refModel(d, s, dir, m));
         acceptCount++;
      end
   endtask

   task automatic waitResult(output int lat, output logic [7:0] data);
      lat  = 99;
      data = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1);
         if (out_valid) begin
            lat  = i;
            data = out_data;
            break;
         end
      end
   endtask

   task automatic directed(input string tag, input logic [7:0] d, input logic [2:0] s,
                           input logic dir, input logic [1:0] m, input logic [7:0] want);
      int lat;
      logic [7:0] got;
      applyStimulus(1'b1, d, s, dir, m, 1'b1);
      waitResult(lat, got);
      checkOutput({tag, "_latency"}, lat, 32'd3);
      checkOutput(tag, {24'd0, got}, {24'd0, want});
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] bpData [5];
   logic [2:0] bpShamt [5];
   logic [1:0] bpMode [5];
   logic       bpDir [5];

   initial begin
      int idx;
      int lat;
      logic [7:0] got;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_shamt = 3'd0;
      in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b0;
      acceptCount = 0; consumeCount = 0;
      repeat (2) @(negedge clk);
      doReset();

      directed("log_right", 8'b10011010, 3'd5, 1'b0, 2'b00, 8'b00000100);
      directed("log_left",  8'b10010011, 3'd7, 1'b1, 2'b00, 8'b10000000);
      directed("ari_right", 8'b10011010, 3'd5, 1'b0, 2'b01, 8'b11111100);
      directed("ari_left",  8'b10010011, 3'd2, 1'b1, 2'b01, 8'b01001100);
`ifdef BARREL_ROTATE_EN
      directed("rot_right", 8'b10011010, 3'd5, 1'b0, 2'b10, 8'b11010100);
      directed("rot_left",  8'b10011010, 3'd3, 1'b1, 2'b10, 8'b11010100);
`else
      directed("rot_right", 8'b10011010, 3'd5, 1'b0, 2'b10, 8'b00000100);
      directed("rot_left",  8'b10011010, 3'd3, 1'b1, 2'b10, 8'b11010000);
`endif
      directed("rsv_right", 8'b10011010, 3'd1, 1'b0, 2'b11, 8'b01001101);
      for (int m = 0; m < 4; m++) begin
         directed("shamt0", 8'hA5, 3'd0, m[0], m[1:0], 8'hA5);
      end

      // Backpressure: five ops offered while the sink refuses results.
      for (int i = 0; i < 5; i++) begin
         bpData[i] = 8'($urandom); bpShamt[i] = 3'($urandom);
         bpMode[i] = 2'($urandom); bpDir[i] = 1'($urandom);
      end
      acceptCount = 0; consumeCount = 0; idx = 0;
      repeat (6) begin
         applyStimulus(1'b1, bpData[idx], bpShamt[idx], bpDir[idx], bpMode[idx], 1'b0);
         if (acceptCount > idx) idx = acceptCount;
      end
      checkOutput("bp_accepts", acceptCount, 32'd3);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_held_data", {24'd0, out_data}, {24'd0, refModel(bpData[0], bpShamt[0], bpDir[0], bpMode[0])});
      for (int c = 0; c < 5; c++) begin
         if (idx < 5) applyStimulus(1'b1, bpData[idx], bpShamt[idx], bpDir[idx], bpMode[idx], 1'b1);
         else         applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1);
         if (acceptCount > idx) idx = acceptCount;
      end
      checkOutput("bp_consumed", consumeCount, 32'd5);
      checkOutput("bp_total_accepts", acceptCount, 32'd5);
      checkOutput("bp_queue_empty", expQ.size(), 32'd0);

      // Reset with three operations in flight; nothing may emerge afterwards.
      repeat (3) applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'b1);
      in_valid = 1'b0;
      doReset();
      consumeCount = 0;
      repeat (6) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1);
      checkOutput("post_rst_results", consumeCount, 32'd0);

      // Randomized traffic with random sink stalls.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom),
                       2'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1);
      checkOutput("rand_drain_empty", expQ.size(), 32'd0);
      waitResult(lat, got);
      checkOutput("rand_idle", lat, 32'd99);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
